// File: rtl/ts_pkg.sv
// ts_pkg
//   Shared constants and helpers for the timestamp_capture block.
//   - TS_WIDTH_DEF / DIV_WIDTH_DEF: default counter and divider widths.
//   - DIV_1US_125MHZ: divider giving a 1 us timestamp step at 125 MHz.
//   - sat_div(): clamps a divider value to a minimum of 1, so a divider
//     of 0 behaves like 1 (increment every enabled cycle).
package ts_pkg;

  localparam int TS_WIDTH_DEF   = 24;
  localparam int DIV_WIDTH_DEF  = 8;
  localparam int DIV_1US_125MHZ = 125;

  // max(x, 1); callers truncate the result back to their divider width.
  function automatic logic [31:0] sat_div(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/ts_capture_chan.sv
// ts_capture_chan
//   One capture channel: a single holding register that latches the
//   current timestamp on an event and is drained over valid/ready.
//   If the register is still full and not being drained when a new event
//   arrives, the old value is kept and a sticky overrun flag is raised.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   cap_event      capture strobe (level, sampled every cycle)
//   cap_ready      consumer accepts cap_data when cap_valid is high
//   overrun_clr    clears the sticky overrun flag
//   timestamp      timestamp value visible this cycle
//   cap_valid      holding register full
//   cap_data       held timestamp
//   cap_overrun    sticky: an event was dropped because the register was full
module ts_capture_chan #(
  parameter int TS_WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap_event,
  input  logic                cap_ready,
  input  logic                overrun_clr,
  input  logic [TS_WIDTH-1:0] timestamp,
  output logic                cap_valid,
  output logic [TS_WIDTH-1:0] cap_data,
  output logic                cap_overrun
);

  logic                valid_reg;
  logic [TS_WIDTH-1:0] data_reg;
  logic                overrun_reg;

  logic pop;
  logic accept;
  logic drop;

  // A pop in the same cycle frees the register, so an event can reload it
  // without a bubble in valid.
  assign pop    = valid_reg & cap_ready;
  assign accept = cap_event & (~valid_reg | pop);
  assign drop   = cap_event & valid_reg & ~cap_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (accept) begin
        data_reg  <= timestamp;
        valid_reg <= 1'b1;
      end else if (pop) begin
        valid_reg <= 1'b0;
      end

      // A new overrun wins over a clear arriving in the same cycle.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign cap_valid   = valid_reg;
  assign cap_data    = data_reg;
  assign cap_overrun = overrun_reg;

endmodule

// File: rtl/timestamp_capture.sv
// timestamp_capture
//   Free-running timestamp counter with a programmable tick divider,
//   software load, enable/freeze and CH_NUM event capture channels.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable         1 = prescaler/timestamp advance, 0 = freeze
//   div_cfg        cycles per timestamp increment (0 treated as 1); picked
//                  up at the next period boundary or on a load
//   load_valid     strobe: timestamp <= load_value, prescaler restarts
//   load_value     value to load
//   timestamp      current timestamp
//   tick           high in the cycle timestamp shows an incremented value
//   wrap           high in the cycle timestamp shows 0 after all-ones
//   cap_event      per-channel capture strobe
//   cap_valid      per-channel holding register full
//   cap_ready      per-channel consumer ready
//   cap_data       captured timestamps, channel 0 in the LSBs
//   cap_overrun    per-channel sticky overrun flag
//   overrun_clr    clears all overrun flags
module timestamp_capture
  import ts_pkg::*;
#(
  parameter int TS_WIDTH    = TS_WIDTH_DEF,
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int DEFAULT_DIV = DIV_1US_125MHZ,
  parameter int CH_NUM      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [DIV_WIDTH-1:0]       div_cfg,
  input  logic                       load_valid,
  input  logic [TS_WIDTH-1:0]        load_value,
  output logic [TS_WIDTH-1:0]        timestamp,
  output logic                       tick,
  output logic                       wrap,
  input  logic [CH_NUM-1:0]          cap_event,
  output logic [CH_NUM-1:0]          cap_valid,
  input  logic [CH_NUM-1:0]          cap_ready,
  output logic [CH_NUM*TS_WIDTH-1:0] cap_data,
  output logic [CH_NUM-1:0]          cap_overrun,
  input  logic                       overrun_clr
);

  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(sat_div(32'(DEFAULT_DIV)));
  localparam logic [TS_WIDTH-1:0]  TS_MAX    = '1;

  logic [DIV_WIDTH-1:0] prescaler_reg;
  logic [DIV_WIDTH-1:0] div_q_reg;
  logic [TS_WIDTH-1:0]  ts_reg;
  logic                 tick_reg;
  logic                 wrap_reg;

  logic [DIV_WIDTH-1:0] div_sat;
  logic                 terminal;

  assign div_sat  = DIV_WIDTH'(sat_div(32'(div_cfg)));
  // div_q_reg is never 0, so div_q_reg-1 cannot underflow.
  assign terminal = (prescaler_reg == (div_q_reg - DIV_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      div_q_reg     <= DIV_RESET;
      ts_reg        <= '0;
      tick_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
      if (load_valid) begin
        // Load discards any terminal-count increment in the same cycle.
        ts_reg        <= load_value;
        prescaler_reg <= '0;
        div_q_reg     <= div_sat;
      end else if (enable) begin
        if (terminal) begin
          prescaler_reg <= '0;
          ts_reg        <= ts_reg + TS_WIDTH'(1);
          // New divider only takes effect at a period boundary.
          div_q_reg     <= div_sat;
          tick_reg      <= 1'b1;
          wrap_reg      <= (ts_reg == TS_MAX);
        end else begin
          prescaler_reg <= prescaler_reg + DIV_WIDTH'(1);
        end
      end
    end
  end

  assign timestamp = ts_reg;
  assign tick      = tick_reg;
  assign wrap      = wrap_reg;

  // Channels sample the registered timestamp, so an event coinciding with
  // a load or increment captures the pre-update value.
  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      ts_capture_chan #(
        .TS_WIDTH(TS_WIDTH)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_event  (cap_event[gi]),
        .cap_ready  (cap_ready[gi]),
        .overrun_clr(overrun_clr),
        .timestamp  (ts_reg),
        .cap_valid  (cap_valid[gi]),
        .cap_data   (cap_data[gi*TS_WIDTH +: TS_WIDTH]),
        .cap_overrun(cap_overrun[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timestamp_capture.sv
// tb_timestamp_capture
//   Directed self-checking bench for timestamp_capture (default parameters:
//   24-bit timestamp, 8-bit divider, default divider 125, two channels).
module tb_timestamp_capture;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  div_cfg;
  logic        load_valid;
  logic [23:0] load_value;
  logic [23:0] timestamp;
  logic        tick;
  logic        wrap;
  logic [1:0]  cap_event;
  logic [1:0]  cap_valid;
  logic [1:0]  cap_ready;
  logic [47:0] cap_data;
  logic [1:0]  cap_overrun;
  logic        overrun_clr;

  int checks   = 0;
  int failures = 0;

  timestamp_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .div_cfg    (div_cfg),
    .load_valid (load_valid),
    .load_value (load_value),
    .timestamp  (timestamp),
    .tick       (tick),
    .wrap       (wrap),
    .cap_event  (cap_event),
    .cap_valid  (cap_valid),
    .cap_ready  (cap_ready),
    .cap_data   (cap_data),
    .cap_overrun(cap_overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    load_valid = 1'b1;
    load_value = v;
    step(1);
    load_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(2);
    checks++;
    if (timestamp !== 24'h0 || tick !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_ts: ts=%h tick=%b wrap=%b required ts=0 tick=0 wrap=0", timestamp, tick, wrap);
    end
    checks++;
    if (cap_valid !== 2'b00 || cap_data !== 48'h0 || cap_overrun !== 2'b00) begin
      failures++;
      $display("FAIL reset_cap: valid=%b data=%h ovr=%b required all 0", cap_valid, cap_data, cap_overrun);
    end
    $display("test_reset done: ts=%h valid=%b", timestamp, cap_valid);
  endtask

  task automatic test_div125;
    int bad;
    bad = 0;
    rst_n   = 1'b1;
    enable  = 1'b1;
    div_cfg = 8'd125;
    for (int k = 1; k <= 250; k++) begin
      step(1);
      if (k == 125 || k == 250) begin
        checks++;
        if (timestamp !== ((k == 125) ? 24'd1 : 24'd2) || tick !== 1'b1) begin
          failures++;
          $display("FAIL div125_inc cycle %0d: ts=%h tick=%b required ts=%0d tick=1", k, timestamp, tick, k / 125);
        end
      end else begin
        checks++;
        if (timestamp !== ((k < 125) ? 24'd0 : 24'd1) || tick !== 1'b0) begin
          bad++;
          failures++;
          if (bad < 4)
            $display("FAIL div125_hold cycle %0d: ts=%h tick=%b required ts=%0d tick=0", k, timestamp, tick, k / 125);
        end
      end
    end
    $display("test_div125 done: ts=%h", timestamp);
  endtask

  task automatic test_wrap;
    div_cfg = 8'd4;
    do_load(24'hFFFFFE);
    checks++;
    if (timestamp !== 24'hFFFFFE || tick !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load: ts=%h tick=%b required ts=fffffe tick=0", timestamp, tick);
    end
    step(3);
    checks++;
    if (timestamp !== 24'hFFFFFE) begin
      failures++;
      $display("FAIL wrap_hold1: ts=%h required fffffe", timestamp);
    end
    step(1);
    checks++;
    if (timestamp !== 24'hFFFFFF || tick !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_inc1: ts=%h tick=%b wrap=%b required ffffff 1 0", timestamp, tick, wrap);
    end
    step(4);
    checks++;
    if (timestamp !== 24'h0 || tick !== 1'b1 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_zero: ts=%h tick=%b wrap=%b required 000000 1 1", timestamp, tick, wrap);
    end
    step(1);
    checks++;
    if (tick !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pulse_width: tick=%b wrap=%b required 0 0", tick, wrap);
    end
    $display("test_wrap done: ts=%h", timestamp);
  endtask

  task automatic test_div_change;
    div_cfg = 8'd125;
    do_load(24'h0);
    step(50);
    div_cfg = 8'd10;   // must not shorten the running 125-cycle period
    step(74);
    checks++;
    if (timestamp !== 24'h0) begin
      failures++;
      $display("FAIL divchg_early: ts=%h required 0", timestamp);
    end
    step(1);
    checks++;
    if (timestamp !== 24'h1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL divchg_end125: ts=%h tick=%b required 1 1", timestamp, tick);
    end
    div_cfg = 8'd0;    // next period still 10 cycles, then every cycle
    step(9);
    checks++;
    if (timestamp !== 24'h1) begin
      failures++;
      $display("FAIL divchg_hold10: ts=%h required 1", timestamp);
    end
    step(1);
    checks++;
    if (timestamp !== 24'h2 || tick !== 1'b1) begin
      failures++;
      $display("FAIL divchg_end10: ts=%h tick=%b required 2 1", timestamp, tick);
    end
    for (int k = 3; k <= 5; k++) begin
      step(1);
      checks++;
      if (timestamp !== 24'(k) || tick !== 1'b1) begin
        failures++;
        $display("FAIL divchg_div0: ts=%h tick=%b required %h 1", timestamp, tick, 24'(k));
      end
    end
    $display("test_div_change done: ts=%h", timestamp);
  endtask

  task automatic test_freeze;
    div_cfg = 8'd20;
    do_load(24'h0);
    step(7);           // prescaler now 7
    enable = 1'b0;
    for (int k = 0; k < 37; k++) begin
      step(1);
      checks++;
      if (timestamp !== 24'h0 || tick !== 1'b0 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL freeze cycle %0d: ts=%h tick=%b wrap=%b required 0 0 0", k, timestamp, tick, wrap);
      end
    end
    enable = 1'b1;     // 13 more edges reach terminal count from prescaler 7
    step(12);
    checks++;
    if (timestamp !== 24'h0) begin
      failures++;
      $display("FAIL freeze_resume_hold: ts=%h required 0", timestamp);
    end
    step(1);
    checks++;
    if (timestamp !== 24'h1 || tick !== 1'b1) begin
      failures++;
      $display("FAIL freeze_resume_inc: ts=%h tick=%b required 1 1", timestamp, tick);
    end
    step(19);          // prescaler now 19 = terminal
    do_load(24'h000123);
    checks++;
    if (timestamp !== 24'h000123 || tick !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_at_terminal: ts=%h tick=%b wrap=%b required 000123 0 0", timestamp, tick, wrap);
    end
    $display("test_freeze done: ts=%h", timestamp);
  endtask

  task automatic test_capture;
    enable    = 1'b0;
    cap_ready = 2'b00;
    do_load(24'h10);
    cap_event = 2'b01;
    step(1);
    cap_event = 2'b00;
    checks++;
    if (cap_valid !== 2'b01 || cap_data[23:0] !== 24'h10 || cap_overrun !== 2'b00) begin
      failures++;
      $display("FAIL cap_first: valid=%b data0=%h ovr=%b required 01 000010 00", cap_valid, cap_data[23:0], cap_overrun);
    end
    do_load(24'h14);
    cap_event = 2'b01;
    step(1);
    cap_event = 2'b00;
    checks++;
    if (cap_valid !== 2'b01 || cap_data[23:0] !== 24'h10 || cap_overrun !== 2'b01) begin
      failures++;
      $display("FAIL cap_overrun: valid=%b data0=%h ovr=%b required 01 000010 01", cap_valid, cap_data[23:0], cap_overrun);
    end
    step(3);
    checks++;
    if (cap_valid !== 2'b01 || cap_data[23:0] !== 24'h10) begin
      failures++;
      $display("FAIL cap_stable: valid=%b data0=%h required 01 000010", cap_valid, cap_data[23:0]);
    end
    do_load(24'h20);
    cap_event = 2'b01;
    cap_ready = 2'b01;
    step(1);
    cap_event = 2'b00;
    cap_ready = 2'b00;
    checks++;
    if (cap_valid !== 2'b01 || cap_data[23:0] !== 24'h20 || cap_overrun !== 2'b01) begin
      failures++;
      $display("FAIL cap_pop_reload: valid=%b data0=%h ovr=%b required 01 000020 01", cap_valid, cap_data[23:0], cap_overrun);
    end
    cap_ready = 2'b01;
    step(1);
    cap_ready = 2'b00;
    checks++;
    if (cap_valid !== 2'b00) begin
      failures++;
      $display("FAIL cap_pop: valid=%b required 00", cap_valid);
    end
    $display("test_capture done: valid=%b ovr=%b", cap_valid, cap_overrun);
  endtask

  task automatic test_overrun_clr;
    do_load(24'h30);
    cap_event = 2'b10;
    step(1);
    checks++;
    if (cap_valid !== 2'b10 || cap_data[47:24] !== 24'h30) begin
      failures++;
      $display("FAIL ch1_capture: valid=%b data1=%h required 10 000030", cap_valid, cap_data[47:24]);
    end
    overrun_clr = 1'b1;  // ch1 overruns in this same cycle
    step(1);
    overrun_clr = 1'b0;
    cap_event   = 2'b00;
    checks++;
    if (cap_overrun !== 2'b10 || cap_data[47:24] !== 24'h30) begin
      failures++;
      $display("FAIL clr_vs_set: ovr=%b data1=%h required 10 000030", cap_overrun, cap_data[47:24]);
    end
    cap_event = 2'b01;
    step(1);
    cap_event = 2'b00;
    checks++;
    if (cap_valid !== 2'b11 || cap_data[23:0] !== 24'h30) begin
      failures++;
      $display("FAIL both_valid: valid=%b data0=%h required 11 000030", cap_valid, cap_data[23:0]);
    end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++;
    if (cap_valid !== 2'b00 || cap_data !== 48'h0 || cap_overrun !== 2'b00 ||
        timestamp !== 24'h0 || tick !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: valid=%b data=%h ovr=%b ts=%h tick=%b wrap=%b required all 0",
               cap_valid, cap_data, cap_overrun, timestamp, tick, wrap);
    end
    $display("test_overrun_clr done: ovr=%b", cap_overrun);
  endtask

  task automatic test_back_to_back;
    enable = 1'b0;
    do_load(24'h40);
    div_cfg    = 8'd0;
    load_valid = 1'b1;
    load_value = 24'h50;
    cap_event  = 2'b01;
    step(1);
    load_valid = 1'b0;
    cap_event  = 2'b00;
    checks++;
    if (cap_data[23:0] !== 24'h40 || timestamp !== 24'h50) begin
      failures++;
      $display("FAIL cap_with_load: data0=%h ts=%h required 000040 000050", cap_data[23:0], timestamp);
    end
    enable    = 1'b1;
    cap_event = 2'b10;
    step(1);
    cap_event = 2'b00;
    checks++;
    if (cap_data[47:24] !== 24'h50 || timestamp !== 24'h51 || tick !== 1'b1) begin
      failures++;
      $display("FAIL cap_with_inc: data1=%h ts=%h tick=%b required 000050 000051 1", cap_data[47:24], timestamp, tick);
    end
    $display("test_back_to_back done: ts=%h", timestamp);
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    div_cfg     = 8'd125;
    load_valid  = 1'b0;
    load_value  = 24'h0;
    cap_event   = 2'b00;
    cap_ready   = 2'b00;
    overrun_clr = 1'b0;

    test_reset();
    test_div125();
    test_wrap();
    test_div_change();
    test_freeze();
    test_capture();
    test_overrun_clr();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
